// File: rtl/jump_redirect_unit.sv
// Fetch PC owner: redirects on JAL/JALR, flushes FLUSH_CYCLES cycles, returns link, traps misaligned targets.
// New pc visible 1 cycle after acceptance; jump_ready/pc_valid low while flushing, stalled on link_ready, or trapped.
module jump_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0004,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fetch_ready,
    output logic [31:0] pc,
    output logic        pc_valid,
    input  logic        jump_valid,
    output logic        jump_ready,
    input  logic [31:0] jumptarg,
    input  logic [31:0] jump_pc,
    input  logic [4:0]  jump_rd,
    output logic        link_valid,
    input  logic        link_ready,
    output logic [4:0]  link_rd,
    output logic [31:0] link_data,
    output logic        flush,
    output logic        misalign,
    output logic [31:0] misalign_addr,
    input  logic        trap_ack
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_LINK  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [3:0]  cnt_q;
    logic        flush_q;
    logic        link_valid_q;
    logic [4:0]  link_rd_q;
    logic [31:0] link_data_q;
    logic        misalign_q;
    logic [31:0] misalign_addr_q;

    logic        run_d;
    logic        jump_acc_d;
    logic [31:0] targ_d;
    logic        link_hs_d;

    // Handshake outputs are forced low while reset is asserted, independent of state.
    assign run_d      = rstn && (state_q == S_RUN);
    assign jump_acc_d = jump_valid && run_d;
    assign targ_d     = {jumptarg[31:1], 1'b0};
    assign link_hs_d  = link_valid_q && link_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q         <= S_RUN;
            pc_q            <= RESET_PC;
            cnt_q           <= 4'd0;
            flush_q         <= 1'b0;
            link_valid_q    <= 1'b0;
            link_rd_q       <= 5'd0;
            link_data_q     <= 32'd0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= 32'd0;
        end else begin
            if (link_hs_d) begin
                link_valid_q <= 1'b0;
            end
            case (state_q)
                S_RUN: begin
                    if (jump_acc_d) begin
                        if (targ_d[1]) begin
                            state_q         <= S_TRAP;
                            misalign_q      <= 1'b1;
                            misalign_addr_q <= targ_d;
                        end else begin
                            state_q <= S_FLUSH;
                            pc_q    <= targ_d;
                            flush_q <= 1'b1;
                            cnt_q   <= FLUSH_INIT;
                            // x0 writes are architecturally dropped, so no link is raised.
                            if (jump_rd != 5'd0) begin
                                link_valid_q <= 1'b1;
                                link_rd_q    <= jump_rd;
                                link_data_q  <= jump_pc + 32'd4;
                            end
                        end
                    end else if (fetch_ready) begin
                        pc_q <= pc_q + 32'd4;
                    end
                end
                S_FLUSH: begin
                    if (cnt_q == 4'd0) begin
                        flush_q <= 1'b0;
                        state_q <= (link_valid_q && !link_ready) ? S_LINK : S_RUN;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_LINK: begin
                    if (!link_valid_q || link_ready) begin
                        state_q <= S_RUN;
                    end
                end
                S_TRAP: begin
                    if (trap_ack) begin
                        state_q    <= S_RUN;
                        pc_q       <= TRAP_VEC;
                        misalign_q <= 1'b0;
                    end
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    assign pc            = pc_q;
    assign pc_valid      = run_d;
    assign jump_ready    = run_d;
    assign flush         = flush_q;
    assign link_valid    = link_valid_q;
    assign link_rd       = link_rd_q;
    assign link_data     = link_data_q;
    assign misalign      = misalign_q;
    assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_jump_redirect_unit.sv
// Directed vector bench for jump_redirect_unit with default parameters.
module tb_jump_redirect_unit;

    logic        clk = 1'b0;
    logic        rstn, fetch_ready, jump_valid, link_ready, trap_ack;
    logic [31:0] jumptarg, jump_pc;
    logic [4:0]  jump_rd;
    logic [31:0] pc, link_data, misalign_addr;
    logic        pc_valid, jump_ready, link_valid, flush, misalign;
    logic [4:0]  link_rd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jump_redirect_unit dut (
        .clk          (clk),
        .rstn         (rstn),
        .fetch_ready  (fetch_ready),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .jump_valid   (jump_valid),
        .jump_ready   (jump_ready),
        .jumptarg     (jumptarg),
        .jump_pc      (jump_pc),
        .jump_rd      (jump_rd),
        .link_valid   (link_valid),
        .link_ready   (link_ready),
        .link_rd      (link_rd),
        .link_data    (link_data),
        .flush        (flush),
        .misalign     (misalign),
        .misalign_addr(misalign_addr),
        .trap_ack     (trap_ack)
    );

    typedef struct {
        logic        rstn, fr, jv;
        logic [31:0] jt, jpc;
        logic [4:0]  rd;
        logic        lr, ta;
        logic [31:0] e_pc;
        logic        e_run, e_fl, e_lv;
        logic [4:0]  e_lrd;
        logic [31:0] e_ld;
        logic        e_mis;
        logic [31:0] e_ma;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic fr, input logic jv, input logic [31:0] jt,
                                input logic [31:0] jpc, input logic [4:0] rd, input logic lr, input logic ta,
                                input logic [31:0] e_pc, input logic e_run, input logic e_fl, input logic e_lv,
                                input logic [4:0] e_lrd, input logic [31:0] e_ld, input logic e_mis,
                                input logic [31:0] e_ma);
        vec_t v;
        v.rstn = r;  v.fr = fr; v.jv = jv; v.jt = jt; v.jpc = jpc; v.rd = rd; v.lr = lr; v.ta = ta;
        v.e_pc = e_pc; v.e_run = e_run; v.e_fl = e_fl; v.e_lv = e_lv;
        v.e_lrd = e_lrd; v.e_ld = e_ld; v.e_mis = e_mis; v.e_ma = e_ma;
        return v;
    endfunction

    task automatic cmp(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, got, exp);
        end
    endtask

    // Drive on the falling edge, check just after the following rising edge.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rstn = v.rstn; fetch_ready = v.fr; jump_valid = v.jv; jumptarg = v.jt;
        jump_pc = v.jpc; jump_rd = v.rd; link_ready = v.lr; trap_ack = v.ta;
        @(posedge clk);
        #1;
        cmp("pc", idx, pc, v.e_pc);
        cmp("pc_valid", idx, 32'(pc_valid), 32'(v.e_run));
        cmp("jump_ready", idx, 32'(jump_ready), 32'(v.e_run));
        cmp("flush", idx, 32'(flush), 32'(v.e_fl));
        cmp("link_valid", idx, 32'(link_valid), 32'(v.e_lv));
        if (v.e_lv) begin
            cmp("link_rd", idx, 32'(link_rd), 32'(v.e_lrd));
            cmp("link_data", idx, link_data, v.e_ld);
        end
        cmp("misalign", idx, 32'(misalign), 32'(v.e_mis));
        cmp("misalign_addr", idx, misalign_addr, v.e_ma);
    endtask

    initial begin
        rstn = 1'b0; fetch_ready = 1'b0; jump_valid = 1'b0; jumptarg = '0;
        jump_pc = '0; jump_rd = '0; link_ready = 1'b0; trap_ack = 1'b0;

        //            rstn fr jv jt            jpc           rd lr ta | pc           run fl lv lrd ld       mis ma
        // reset and sequential fetch
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0, 0,  32'h0,        0, 0, 0, 0, 32'h0,     0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0, 0,  32'h0,        0, 0, 0, 0, 32'h0,     0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0,        32'h0,        0, 0, 0,  32'h4,        1, 0, 0, 0, 32'h0,     0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0,        32'h0,        0, 0, 0,  32'h8,        1, 0, 0, 0, 32'h0,     0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0,        32'h0,        0, 0, 0,  32'hC,        1, 0, 0, 0, 32'h0,     0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 0, 0,  32'hC,        1, 0, 0, 0, 32'h0,     0, 32'h0));
        // jump to 0x100 with rd=0; fetch_ready ignored while flushing
        tbl.push_back(mk(1, 0, 1, 32'h100,      32'hC,        0, 0, 0,  32'h100,      0, 1, 0, 0, 32'h0,     0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0,        32'h0,        0, 0, 0,  32'h100,      0, 1, 0, 0, 32'h0,     0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0,        32'h0,        0, 0, 0,  32'h100,      1, 0, 0, 0, 32'h0,     0, 32'h0));
        // aligned JAL with link, link accepted during flush
        tbl.push_back(mk(1, 1, 1, 32'h2000,     32'h100,      1, 1, 0,  32'h2000,     0, 1, 1, 1, 32'h104,   0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 1, 0,  32'h2000,     0, 1, 0, 0, 32'h0,     0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 1, 0,  32'h2000,     1, 0, 0, 0, 32'h0,     0, 32'h0));
        // odd JALR target, rd=0
        tbl.push_back(mk(1, 0, 1, 32'h3001,     32'h2000,     0, 1, 0,  32'h3000,     0, 1, 0, 0, 32'h0,     0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 1, 0,  32'h3000,     0, 1, 0, 0, 32'h0,     0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 1, 0,  32'h3000,     1, 0, 0, 0, 32'h0,     0, 32'h0));
        // misaligned target, ack three cycles later
        tbl.push_back(mk(1, 1, 1, 32'h3002,     32'h3000,     3, 1, 0,  32'h3000,     0, 0, 0, 0, 32'h0,     1, 32'h3002));
        tbl.push_back(mk(1, 1, 0, 32'h0,        32'h0,        0, 1, 0,  32'h3000,     0, 0, 0, 0, 32'h0,     1, 32'h3002));
        tbl.push_back(mk(1, 1, 0, 32'h0,        32'h0,        0, 1, 0,  32'h3000,     0, 0, 0, 0, 32'h0,     1, 32'h3002));
        tbl.push_back(mk(1, 1, 0, 32'h0,        32'h0,        0, 1, 1,  32'h4,        1, 0, 0, 0, 32'h0,     0, 32'h3002));
        // stray trap_ack in RUN is ignored
        tbl.push_back(mk(1, 1, 0, 32'h0,        32'h0,        0, 1, 1,  32'h8,        1, 0, 0, 0, 32'h0,     0, 32'h3002));
        // jump wins over fetch_ready
        tbl.push_back(mk(1, 1, 1, 32'h4000,     32'h8,        0, 1, 0,  32'h4000,     0, 1, 0, 0, 32'h0,     0, 32'h3002));
        tbl.push_back(mk(1, 1, 0, 32'h0,        32'h0,        0, 1, 0,  32'h4000,     0, 1, 0, 0, 32'h0,     0, 32'h3002));
        tbl.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 1, 0,  32'h4000,     1, 0, 0, 0, 32'h0,     0, 32'h3002));
        // jump to top of memory, link_data wraps, then pc wraps
        tbl.push_back(mk(1, 0, 1, 32'hFFFFFFFD, 32'hFFFFFFFC, 2, 1, 0,  32'hFFFFFFFC, 0, 1, 1, 2, 32'h0,     0, 32'h3002));
        tbl.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 1, 0,  32'hFFFFFFFC, 0, 1, 0, 0, 32'h0,     0, 32'h3002));
        tbl.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 1, 0,  32'hFFFFFFFC, 1, 0, 0, 0, 32'h0,     0, 32'h3002));
        tbl.push_back(mk(1, 1, 0, 32'h0,        32'h0,        0, 1, 0,  32'h0,        1, 0, 0, 0, 32'h0,     0, 32'h3002));
        // reset during flush with link pending
        tbl.push_back(mk(1, 0, 1, 32'h600,      32'h0,        7, 0, 0,  32'h600,      0, 1, 1, 7, 32'h4,     0, 32'h3002));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0, 0,  32'h0,        0, 0, 0, 0, 32'h0,     0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 0, 0,  32'h0,        1, 0, 0, 0, 32'h0,     0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0,        32'h0,        0, 0, 0,  32'h4,        1, 0, 0, 0, 32'h0,     0, 32'h0));

        foreach (tbl[i]) apply(tbl[i], i);

        // Link stall: link_ready held low, unit parks in LINK with link stable.
        apply(mk(1, 1, 1, 32'h5000, 32'h4, 5, 0, 0, 32'h5000, 0, 1, 1, 5, 32'h8, 0, 32'h0), 100);
        for (int k = 0; k < 5; k++) begin
            apply(mk(1, 1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h5000, 0, (k == 0), 1, 5, 32'h8, 0, 32'h0), 101 + k);
        end
        apply(mk(1, 1, 0, 32'h0, 32'h0, 0, 1, 0, 32'h5000, 1, 0, 0, 0, 32'h0, 0, 32'h0), 106);
        apply(mk(1, 1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h5004, 1, 0, 0, 0, 32'h0, 0, 32'h0), 107);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
